// File: rtl/out_seq_ctrl_if.sv
// Handshake and beat bus of the output-sequencing controller.
// The datapath side drives the requests; the controller answers with read beats.
interface out_seq_ctrl_if #(
   parameter int CH_W   = 4,
   parameter int ADDR_W = 12
);
   logic              run;
   logic              s_init;
   logic              k_fin;
   logic              rev;
   logic [CH_W-1:0]   od;
   logic [ADDR_W-1:0] os;
   logic              out_busy;
   logic              outr;
   logic [CH_W-1:0]   ra;
   logic [ADDR_W-1:0] oa;
   logic              burst_done;
   logic              pend_ovf;

   modport master (
      output run, s_init, k_fin, rev, od, os,
      input  out_busy, outr, ra, oa, burst_done, pend_ovf
   );

   modport slave (
      input  run, s_init, k_fin, rev, od, os,
      output out_busy, outr, ra, oa, burst_done, pend_ovf
   );
endinterface

// File: rtl/out_seq_ctrl.sv
// Output-sequencing controller: each kernel-finish issues one read beat per
// output channel (forward or reverse order), with a one-deep request queue.
module out_seq_ctrl #(
   parameter int CH_W   = 4,
   parameter int ADDR_W = 12,
   parameter int POS_W  = 10
) (
   input logic          clk,
   input logic          rst_n,
   out_seq_ctrl_if.slave bus
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] ISSUE = 1'b1;

   localparam logic [CH_W-1:0]  CNT_ONE = CH_W'(1);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   logic [0:0]        state_q, state_d;
   logic [CH_W-1:0]   cnt_q, cnt_d;
   logic              rev_q, rev_d;
   logic              first_q, first_d;
   logic              pend_q, pend_d;
   logic              ovf_q, ovf_d;
   logic [POS_W-1:0]  pos_q, pos_d;
   logic              outr_q, outr_d;
   logic [CH_W-1:0]   ra_q, ra_d;
   logic [ADDR_W-1:0] oa_q, oa_d;
   logic              last_q, last_d;

   logic              out0;
   logic              last_beat;
   logic [CH_W-1:0]   start_cnt;

   assign out0      = (state_q == ISSUE);
   assign last_beat = out0 && (rev_q ? (cnt_q == '0) : (cnt_q == bus.od));
   assign start_cnt = bus.rev ? bus.od : '0;

   // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rev_d   = rev_q;
      first_d = first_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      pos_d   = pos_q;
      outr_d  = out0;
      ra_d    = ra_q;
      oa_d    = oa_q;
      last_d  = last_beat;

      // Stage1: register the beat walked by stage0 this cycle.
      if (out0) begin
         ra_d = cnt_q;
         oa_d = first_q ? ADDR_W'(pos_q) : oa_q + bus.os;
      end

      case (state_q)
         IDLE: begin
            if (bus.k_fin) begin
               state_d = ISSUE;
               rev_d   = bus.rev;
               cnt_d   = start_cnt;
               first_d = 1'b1;
            end
         end
         default: begin
            if (last_beat) begin
               // A queued or simultaneous request restarts with no idle gap.
               if (pend_q || bus.k_fin) begin
                  rev_d   = bus.rev;
                  cnt_d   = start_cnt;
                  first_d = 1'b1;
                  pend_d  = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d   = rev_q ? cnt_q - CNT_ONE : cnt_q + CNT_ONE;
               first_d = 1'b0;
               if (bus.k_fin && !pend_q) pend_d = 1'b1;
            end
         end
      endcase

      if (bus.k_fin && pend_q) ovf_d = 1'b1;

      if (bus.s_init)      pos_d = '0;
      else if (last_beat)  pos_d = pos_q + POS_ONE;

      if (!bus.run) begin
         state_d = IDLE;
         cnt_d   = '0;
         rev_d   = 1'b0;
         first_d = 1'b0;
         pend_d  = 1'b0;
         ovf_d   = 1'b0;
         pos_d   = '0;
         outr_d  = 1'b0;
         ra_d    = '0;
         oa_d    = '0;
         last_d  = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rev_q   <= 1'b0;
         first_q <= 1'b0;
         pend_q  <= 1'b0;
         ovf_q   <= 1'b0;
         pos_q   <= '0;
         outr_q  <= 1'b0;
         ra_q    <= '0;
         oa_q    <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rev_q   <= rev_d;
         first_q <= first_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         pos_q   <= pos_d;
         outr_q  <= outr_d;
         ra_q    <= ra_d;
         oa_q    <= oa_d;
         last_q  <= last_d;
      end
   end

   assign bus.out_busy   = out0 | pend_q;
   assign bus.outr       = outr_q;
   assign bus.ra         = ra_q;
   assign bus.oa         = oa_q;
   assign bus.burst_done = outr_q & last_q;
   assign bus.pend_ovf   = ovf_q;

endmodule

// File: tb/tb_out_seq_ctrl.sv
// Directed bench for out_seq_ctrl: single, reverse, back-to-back, wrap,
// run-clear and asynchronous-reset scenarios with hand-derived beats.
module tb_out_seq_ctrl;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_bad;

   out_seq_ctrl_if #(.CH_W(4), .ADDR_W(12)) bus ();

   out_seq_ctrl #(.CH_W(4), .ADDR_W(12), .POS_W(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic run_burst(input logic [3:0] od_v, input logic [11:0] os_v,
                            input logic rev_v, input logic [11:0] first_v, input string name);
      logic [11:0] exp_oa;
      logic [3:0]  exp_ra;
      bus.od    = od_v;
      bus.os    = os_v;
      bus.rev   = rev_v;
      bus.k_fin = 1'b1;
      tick();
      bus.k_fin = 1'b0;
      check({name, ".busy0"}, 32'(bus.out_busy), 32'd1);
      check({name, ".outr0"}, 32'(bus.outr), 32'd0);
      exp_oa = first_v;
      for (int i = 0; i <= int'(od_v); i++) begin
         tick();
         exp_ra = rev_v ? od_v - 4'(i) : 4'(i);
         check($sformatf("%s.outr[%0d]", name, i), 32'(bus.outr), 32'd1);
         check($sformatf("%s.ra[%0d]", name, i), 32'(bus.ra), 32'(exp_ra));
         check($sformatf("%s.oa[%0d]", name, i), 32'(bus.oa), 32'(exp_oa));
         check($sformatf("%s.done[%0d]", name, i), 32'(bus.burst_done), 32'(i == int'(od_v)));
         check($sformatf("%s.busy[%0d]", name, i), 32'(bus.out_busy), 32'(i < int'(od_v)));
         exp_oa = exp_oa + os_v;
      end
      tick();
      check({name, ".outr_end"}, 32'(bus.outr), 32'd0);
   endtask

   // k_fin pattern and expected beat oa for the back-to-back scenario (od=2, os=5)
   logic [0:0]  b2b_kfin [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   logic [11:0] b2b_oa   [6] = '{12'd0, 12'd5, 12'd10, 12'd1, 12'd6, 12'd11};
   logic [3:0]  b2b_ra   [6] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2};

   initial begin
      n_chk      = 0;
      n_bad      = 0;
      rst_n      = 1'b0;
      bus.run    = 1'b0;
      bus.s_init = 1'b0;
      bus.k_fin  = 1'b0;
      bus.rev    = 1'b0;
      bus.od     = '0;
      bus.os     = '0;
      tick();
      tick();
      check("rst.outr", 32'(bus.outr), 32'd0);
      check("rst.oa", 32'(bus.oa), 32'd0);
      check("rst.busy", 32'(bus.out_busy), 32'd0);
      check("rst.ovf", 32'(bus.pend_ovf), 32'd0);
      rst_n   = 1'b1;
      bus.run = 1'b1;
      tick();

      // Forward burst from pos 0, then reverse burst from pos 1.
      run_burst(4'd3, 12'd16, 1'b0, 12'd0, "fwd");
      run_burst(4'd3, 12'd16, 1'b1, 12'd1, "rev");
      bus.s_init = 1'b1;
      tick();
      bus.s_init = 1'b0;
      run_burst(4'd3, 12'd16, 1'b0, 12'd0, "init");

      // Back-to-back: second k_fin queues, third is dropped and sets pend_ovf.
      bus.s_init = 1'b1;
      tick();
      bus.s_init = 1'b0;
      bus.od  = 4'd2;
      bus.os  = 12'd5;
      bus.rev = 1'b0;
      bus.k_fin = b2b_kfin[0];
      tick();
      for (int i = 0; i < 6; i++) begin
         bus.k_fin = b2b_kfin[i+1];
         tick();
         check($sformatf("b2b.outr[%0d]", i), 32'(bus.outr), 32'd1);
         check($sformatf("b2b.ra[%0d]", i), 32'(bus.ra), 32'(b2b_ra[i]));
         check($sformatf("b2b.oa[%0d]", i), 32'(bus.oa), 32'(b2b_oa[i]));
         check($sformatf("b2b.done[%0d]", i), 32'(bus.burst_done), 32'(i == 2 || i == 5));
      end
      check("b2b.busy_end", 32'(bus.out_busy), 32'd0);
      check("b2b.ovf", 32'(bus.pend_ovf), 32'd1);
      tick();
      check("b2b.ovf_sticky", 32'(bus.pend_ovf), 32'd1);
      bus.run = 1'b0;
      tick();
      check("b2b.ovf_clr", 32'(bus.pend_ovf), 32'd0);
      bus.run = 1'b1;
      tick();

      // Address wrap: 0, 2050, 4100 mod 4096 = 4.
      run_burst(4'd2, 12'd2050, 1'b0, 12'd0, "awrap");

      // Position wrap: hold k_fin with od=0, one burst per cycle.
      bus.s_init = 1'b1;
      tick();
      bus.s_init = 1'b0;
      bus.od    = 4'd0;
      bus.os    = 12'd0;
      bus.k_fin = 1'b1;
      tick();
      for (int i = 0; i <= 1024; i++) begin
         tick();
         if (i == 1023) begin
            check("pwrap.oa1023", 32'(bus.oa), 32'd1023);
            check("pwrap.done", 32'(bus.burst_done), 32'd1);
         end
         if (i == 1024) check("pwrap.oa0", 32'(bus.oa), 32'd0);
      end
      bus.k_fin = 1'b0;
      tick();
      tick();
      check("pwrap.idle", 32'(bus.out_busy), 32'd0);

      // run low at the middle beat, with a pending request and an overflow.
      bus.od    = 4'd2;
      bus.os    = 12'd1;
      bus.k_fin = 1'b1;
      tick();
      tick();
      tick();
      check("runclr.mid_outr", 32'(bus.outr), 32'd1);
      check("runclr.mid_ra", 32'(bus.ra), 32'd1);
      check("runclr.mid_ovf", 32'(bus.pend_ovf), 32'd1);
      bus.k_fin = 1'b0;
      bus.run   = 1'b0;
      tick();
      check("runclr.outr", 32'(bus.outr), 32'd0);
      check("runclr.ra", 32'(bus.ra), 32'd0);
      check("runclr.busy", 32'(bus.out_busy), 32'd0);
      check("runclr.ovf", 32'(bus.pend_ovf), 32'd0);
      bus.run = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("runclr.quiet_outr[%0d]", i), 32'(bus.outr), 32'd0);
         check($sformatf("runclr.quiet_busy[%0d]", i), 32'(bus.out_busy), 32'd0);
      end

      // Asynchronous reset between edges mid-burst.
      bus.od    = 4'd3;
      bus.os    = 12'd7;
      bus.k_fin = 1'b1;
      tick();
      bus.k_fin = 1'b0;
      tick();
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst.outr", 32'(bus.outr), 32'd0);
      check("arst.ra", 32'(bus.ra), 32'd0);
      check("arst.oa", 32'(bus.oa), 32'd0);
      check("arst.busy", 32'(bus.out_busy), 32'd0);
      rst_n = 1'b1;
      tick();
      run_burst(4'd0, 12'd9, 1'b1, 12'd0, "single");

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
